// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader:
// FSM state encoding and byte-stream framing constants.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_CSUM   = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    localparam int HDR_LEN        = 2;
    localparam int BYTES_PER_WORD = 4;

    function automatic logic state_accepts(input state_t s);
        case (s)
            S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// Assembles little-endian 32-bit words from accepted data bytes and emits a
// registered one-cycle word-complete pulse with the finished word.
module byte_to_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [7:0]  data_in,
    output logic        last_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0] byte_cnt;
    logic [31:0]      shreg;
    logic [31:0]      assembled;

    // Newest byte enters at the top, so the first byte ends up least significant.
    assign assembled = {data_in, shreg[31:8]};
    assign last_byte = load && (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));

    // Shift register, byte counter and registered word output.
    always_ff @(posedge clock) begin
        if (reset) begin
            byte_cnt   <= CNT_W'(0);
            shreg      <= 32'h0000_0000;
            word_valid <= 1'b0;
            word       <= 32'h0000_0000;
        end else begin
            word_valid <= last_byte;
            if (load) begin
                byte_cnt <= byte_cnt + CNT_W'(1);
                shreg    <= assembled;
            end
            if (last_byte) begin
                word <= assembled;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses length / data / checksum byte stream, writes words into
// instruction memory and holds the core in reset until a verified load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            in_byte,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam int LEN_BITS = HDR_LEN * 8;
    localparam int WCNT_W   = ADDR_WIDTH + 1;
    localparam logic [LEN_BITS-1:0] DEPTH = LEN_BITS'(1) << ADDR_WIDTH;

    state_t              state;
    state_t              state_next;
    logic [LEN_BITS-1:0] len;
    logic [LEN_BITS-1:0] len_full;
    logic [WCNT_W-1:0]   word_cnt;
    logic [7:0]          csum;
    logic                accept;
    logic                data_load;
    logic                last_byte;
    logic                last_word;

    assign in_ready  = !reset && state_accepts(state);
    assign accept    = in_valid && in_ready;
    assign data_load = accept && (state == S_DATA);
    assign len_full  = {in_byte, len[7:0]};
    assign last_word = (LEN_BITS'(word_cnt) + LEN_BITS'(1)) == len;

    byte_to_word_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .load       (data_load),
        .data_in    (in_byte),
        .last_byte  (last_byte),
        .word_valid (imem_we),
        .word       (imem_wdata)
    );

    // Next-state logic; illegal encodings fall into the error state.
    always_comb begin
        state_next = state;
        case (state)
            S_LEN_LO: begin
                if (accept) state_next = S_LEN_HI;
                else        state_next = state;
            end
            S_LEN_HI: begin
                if (!accept)                       state_next = state;
                else if (len_full > DEPTH)         state_next = S_ERROR;
                else if (len_full == LEN_BITS'(0)) state_next = S_CSUM;
                else                               state_next = S_DATA;
            end
            S_DATA: begin
                if (last_byte && last_word) state_next = S_CSUM;
                else                        state_next = state;
            end
            S_CSUM: begin
                if (!accept)              state_next = state;
                else if (in_byte == csum) state_next = S_DONE;
                else                      state_next = S_ERROR;
            end
            S_DONE:  state_next = S_DONE;
            S_ERROR: state_next = S_ERROR;
            default: state_next = S_ERROR;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_LEN_LO;
        end else begin
            state <= state_next;
        end
    end

    // Length, word counter, running XOR, write address and status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            len       <= LEN_BITS'(0);
            word_cnt  <= WCNT_W'(0);
            csum      <= 8'h00;
            imem_addr <= ADDR_WIDTH'(0);
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            cpu_hold <= (state_next != S_DONE);
            done     <= (state_next == S_DONE);
            error    <= (state_next == S_ERROR);
            if (accept && state == S_LEN_LO) len[7:0] <= in_byte;
            if (accept && state == S_LEN_HI) len[LEN_BITS-1:8] <= in_byte;
            if (data_load) csum <= csum ^ in_byte;
            if (last_byte) begin
                imem_addr <= word_cnt[ADDR_WIDTH-1:0];
                word_cnt  <= word_cnt + WCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random byte streams
// compared against a stream-level reference model.
module tb_imem_loader;

    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic            clock    = 1'b0;
    logic            reset    = 1'b1;
    logic            in_valid = 1'b0;
    logic [7:0]      in_byte  = 8'h00;
    logic            in_ready;
    logic            imem_we;
    logic [AW-1:0]   imem_addr;
    logic [31:0]     imem_wdata;
    logic            cpu_hold;
    logic            done;
    logic            error;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int stalls   = 0;

    logic [7:0]  stim[$];
    int          acc_cyc[$];
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    logic [31:0] exp_w[$];
    logic        exp_done;
    logic        exp_error;
    int          exp_last;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Record every write strobe with the cycle it was seen in.
    always @(negedge clock) begin
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(int'(imem_addr));
            wr_data_q.push_back(imem_wdata);
            wr_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        wr_addr_q = {};
        wr_data_q = {};
        wr_cyc_q  = {};
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        clear_log();
    endtask

    // Stream-level model: length header, little-endian words, XOR checksum.
    task automatic run_model();
        int         n;
        logic [7:0] x;
        n = int'(stim[0]) + 256 * int'(stim[1]);
        exp_w = {};
        x = 8'h00;
        if (n > DEPTH) begin
            exp_done  = 1'b0;
            exp_error = 1'b1;
            exp_last  = 1;
        end else begin
            for (int k = 0; k < n; k++)
                exp_w.push_back({stim[2+4*k+3], stim[2+4*k+2], stim[2+4*k+1], stim[2+4*k]});
            for (int i = 2; i < 2 + 4 * n; i++)
                x = x ^ stim[i];
            exp_last  = 2 + 4 * n;
            exp_done  = (stim[exp_last] == x);
            exp_error = !exp_done;
        end
    endtask

    task automatic drive(input int max_gap);
        acc_cyc = {};
        stalls  = 0;
        foreach (stim[i]) begin
            int g;
            int waited;
            g = $urandom_range(max_gap, 0);
            waited = 0;
            repeat (g) begin
                @(negedge clock);
                in_valid = 1'b0;
            end
            @(negedge clock);
            in_valid = 1'b1;
            in_byte  = stim[i];
            while (in_ready !== 1'b1 && waited < 20) begin
                @(negedge clock);
                waited++;
                stalls++;
            end
            if (in_ready !== 1'b1) begin
                n_checks++;
                n_fail++;
                $display("FAIL drive_timeout byte %0d: in_ready=%b, required 1", i, in_ready);
                in_valid = 1'b0;
                return;
            end
            acc_cyc.push_back(cyc);
            @(posedge clock);
        end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic check_stream(input string name);
        int idx;
        run_model();
        n_checks++;
        if (acc_cyc.size() != exp_last + 1) begin
            n_fail++;
            $display("FAIL %s accepted: got %0d bytes, required %0d", name, acc_cyc.size(), exp_last + 1);
        end
        n_checks++;
        if (done !== exp_done) begin
            n_fail++;
            $display("FAIL %s done: got %b, required %b", name, done, exp_done);
        end
        n_checks++;
        if (error !== exp_error) begin
            n_fail++;
            $display("FAIL %s error: got %b, required %b", name, error, exp_error);
        end
        n_checks++;
        if (cpu_hold !== !exp_done) begin
            n_fail++;
            $display("FAIL %s cpu_hold: got %b, required %b", name, cpu_hold, !exp_done);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s in_ready_terminal: got %b, required 0", name, in_ready);
        end
        n_checks++;
        if (stalls != 0) begin
            n_fail++;
            $display("FAIL %s stalls: got %0d, required 0", name, stalls);
        end
        repeat (3) @(negedge clock);
        n_checks++;
        if (wr_addr_q.size() != exp_w.size()) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d, required %0d", name, wr_addr_q.size(), exp_w.size());
        end
        for (int k = 0; k < exp_w.size() && k < wr_addr_q.size(); k++) begin
            n_checks++;
            if (wr_addr_q[k] != k) begin
                n_fail++;
                $display("FAIL %s addr[%0d]: got %0d, required %0d", name, k, wr_addr_q[k], k);
            end
            n_checks++;
            if (wr_data_q[k] !== exp_w[k]) begin
                n_fail++;
                $display("FAIL %s data[%0d]: got %h, required %h", name, k, wr_data_q[k], exp_w[k]);
            end
            idx = 2 + 4 * k + 3;
            if (idx < acc_cyc.size()) begin
                n_checks++;
                if (wr_cyc_q[k] != acc_cyc[idx] + 1) begin
                    n_fail++;
                    $display("FAIL %s wr_cycle[%0d]: got %0d, required %0d", name, k, wr_cyc_q[k], acc_cyc[idx] + 1);
                end
            end
        end
    endtask

    task automatic load_first(input logic [7:0] cs);
        stim = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, cs};
    endtask

    task automatic build(input int n, input bit bad);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        stim = {};
        stim.push_back(8'(n));
        stim.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            stim.push_back(b);
            x = x ^ b;
        end
        if (bad) x = x ^ 8'($urandom_range(255, 1));
        stim.push_back(x);
    endtask

    task automatic test_reset();
        @(negedge clock);
        n_checks++;
        if (in_ready !== 1'b0 || imem_we !== 1'b0 || imem_addr !== 8'h00 || imem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b we=%b addr=%h wdata=%h, required 0 0 00 00000000",
                     in_ready, imem_we, imem_addr, imem_wdata);
        end
        n_checks++;
        if (cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: got hold=%b done=%b err=%b, required 1 0 0", cpu_hold, done, error);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after: got %b, required 1", in_ready);
        end
        clear_log();
    endtask

    task automatic test_directed();
        do_reset(); load_first(8'h2A); drive(0); check_stream("good_two_words");
        do_reset(); stim = {8'h00, 8'h00, 8'h00}; drive(0); check_stream("zero_length");
        do_reset(); load_first(8'h2B); drive(0); check_stream("bad_checksum");
        do_reset(); stim = {8'h01, 8'h01}; drive(0); check_stream("len_overflow");
    endtask

    task automatic test_gaps();
        for (int r = 0; r < 3; r++) begin
            do_reset(); load_first(8'h2A); drive(5); check_stream("gapped_stream");
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        load_first(8'h2A);
        stim = stim[0:5];
        drive(0);
        repeat (2) @(negedge clock);
        n_checks++;
        if (wr_addr_q.size() != 1 || (wr_addr_q.size() == 1 && wr_data_q[0] !== 32'h12345678)) begin
            n_fail++;
            $display("FAIL reset_mid_first_pass: got %0d writes, required 1 of 12345678", wr_addr_q.size());
        end
        do_reset(); load_first(8'h2A); drive(0); check_stream("reset_mid_resend");
        // Fourth byte of a word presented while reset is high must not write.
        do_reset();
        stim = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34};
        drive(0);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'h12;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cycle_ready: got %b, required 0", in_ready);
        end
        @(negedge clock);
        reset    = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (imem_we !== 1'b0 || wr_addr_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_4th_byte_write: got we=%b writes=%0d, required 0 0", imem_we, wr_addr_q.size());
        end
        clear_log();
        load_first(8'h2A); drive(0); check_stream("after_reset_4th");
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            do_reset();
            build($urandom_range(6, 0), ($urandom_range(3, 0) == 0));
            drive(3);
            check_stream("random_stream");
        end
    endtask

    task automatic test_boundary();
        do_reset(); build(DEPTH, 1'b0); drive(0); check_stream("full_depth");
        do_reset(); stim = {8'h01, 8'h01}; drive(2); check_stream("depth_plus_one");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_gaps();
        test_reset_mid();
        test_random();
        test_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
